// File: rtl/ili9341_rgb_timing.sv
// ILI9341 RGB-interface timing generator: lock qualification, H/V scan counters,
// and a two-stage output pipeline that requests each pixel one cycle ahead of DE.
module ili9341_rgb_timing #(
  parameter int H_ACTIVE  = 240,
  parameter int H_FP      = 10,
  parameter int H_SYNC    = 10,
  parameter int H_BP      = 20,
  parameter int V_ACTIVE  = 320,
  parameter int V_FP      = 4,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 2,
  parameter int LOCK_WAIT = 1024,
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
  input  logic          clock_in,
  input  logic          reset_n,
  input  logic          locked,
  input  logic          enable,
  output logic          req_valid,
  output logic [XW-1:0] req_x,
  output logic [YW-1:0] req_y,
  output logic          hsync_n,
  output logic          vsync_n,
  output logic          de,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y,
  output logic          frame_start,
  output logic          running
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int LW      = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_END  = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_START = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_ACT_END   = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END  = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_START = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_ACT_END   = VW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_WAIT - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2
  } state_e;

  function automatic logic [XW-1:0] col_of(input logic [HW-1:0] h);
    return XW'(h - H_ACT_START);
  endfunction

  function automatic logic [YW-1:0] row_of(input logic [VW-1:0] v);
    return YW'(v - V_ACT_START);
  endfunction

  logic          lock_meta_q;
  logic          lock_sync_q;
  state_e        state_q;
  logic [LW-1:0] lock_cnt_q;
  logic [HW-1:0] h_cnt_q;
  logic [VW-1:0] v_cnt_q;

  logic          h_wrap;
  logic          v_wrap;
  logic          h_act;
  logic          v_act;
  logic          run_ok;
  logic          lock_lost;

  // Stage 1 next values and registers (request stage)
  logic          req_valid_d;
  logic [XW-1:0] req_x_d;
  logic [YW-1:0] req_y_d;
  logic          hs_d;
  logic          vs_d;
  logic          fs_d;
  logic          req_valid_p1_q;
  logic [XW-1:0] req_x_p1_q;
  logic [YW-1:0] req_y_p1_q;
  logic          hs_p1_q;
  logic          vs_p1_q;
  logic          fs_p1_q;

  // Stage 2 registers (display stage)
  logic          de_p2_q;
  logic [XW-1:0] px_p2_q;
  logic [YW-1:0] py_p2_q;
  logic          hs_p2_q;
  logic          vs_p2_q;
  logic          fs_p2_q;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= locked;
      lock_sync_q <= lock_meta_q;
    end
  end

  assign h_wrap    = (h_cnt_q == H_LAST);
  assign v_wrap    = (v_cnt_q == V_LAST);
  assign run_ok    = (state_q == RUN) && lock_sync_q;
  assign lock_lost = (state_q == RUN) && !lock_sync_q;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= WAIT_LOCK;
      lock_cnt_q <= '0;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          lock_cnt_q <= '0;
          h_cnt_q    <= '0;
          v_cnt_q    <= '0;
          if (lock_sync_q) state_q <= STABILIZE;
        end
        STABILIZE: begin
          h_cnt_q <= '0;
          v_cnt_q <= '0;
          if (!lock_sync_q) begin
            state_q    <= WAIT_LOCK;
            lock_cnt_q <= '0;
          end else if (lock_cnt_q == LOCK_LAST) begin
            // Count stays saturated here until scanning is enabled.
            if (enable) state_q <= RUN;
          end else begin
            lock_cnt_q <= lock_cnt_q + LW'(1);
          end
        end
        RUN: begin
          if (!lock_sync_q) begin
            state_q    <= WAIT_LOCK;
            lock_cnt_q <= '0;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
          end else begin
            if (h_wrap) begin
              h_cnt_q <= '0;
              v_cnt_q <= v_wrap ? '0 : v_cnt_q + VW'(1);
            end else begin
              h_cnt_q <= h_cnt_q + HW'(1);
            end
            // Disable only takes effect on a frame boundary.
            if (h_wrap && v_wrap && !enable) begin
              state_q    <= STABILIZE;
              lock_cnt_q <= LOCK_LAST;
            end
          end
        end
        default: begin
          state_q    <= WAIT_LOCK;
          lock_cnt_q <= '0;
          h_cnt_q    <= '0;
          v_cnt_q    <= '0;
        end
      endcase
    end
  end

  assign h_act = (h_cnt_q >= H_ACT_START) && (h_cnt_q < H_ACT_END);
  assign v_act = (v_cnt_q >= V_ACT_START) && (v_cnt_q < V_ACT_END);

  always_comb begin
    req_valid_d = 1'b0;
    req_x_d     = '0;
    req_y_d     = '0;
    hs_d        = 1'b1;
    vs_d        = 1'b1;
    fs_d        = 1'b0;
    if (run_ok) begin
      hs_d = !(h_cnt_q < H_SYNC_END);
      vs_d = !(v_cnt_q < V_SYNC_END);
      fs_d = (h_cnt_q == '0) && (v_cnt_q == '0);
      if (h_act && v_act) begin
        req_valid_d = 1'b1;
        req_x_d     = col_of(h_cnt_q);
        req_y_d     = row_of(v_cnt_q);
      end
    end
  end

  // Stage 1 -> stage 2 boundary
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      req_valid_p1_q <= 1'b0;
      req_x_p1_q     <= '0;
      req_y_p1_q     <= '0;
      hs_p1_q        <= 1'b1;
      vs_p1_q        <= 1'b1;
      fs_p1_q        <= 1'b0;
      de_p2_q        <= 1'b0;
      px_p2_q        <= '0;
      py_p2_q        <= '0;
      hs_p2_q        <= 1'b1;
      vs_p2_q        <= 1'b1;
      fs_p2_q        <= 1'b0;
    end else begin
      req_valid_p1_q <= req_valid_d;
      req_x_p1_q     <= req_x_d;
      req_y_p1_q     <= req_y_d;
      hs_p1_q        <= hs_d;
      vs_p1_q        <= vs_d;
      fs_p1_q        <= fs_d;
      if (lock_lost) begin
        // Losing lock drops the partial frame: display stage goes idle at once.
        de_p2_q <= 1'b0;
        px_p2_q <= '0;
        py_p2_q <= '0;
        hs_p2_q <= 1'b1;
        vs_p2_q <= 1'b1;
        fs_p2_q <= 1'b0;
      end else begin
        de_p2_q <= req_valid_p1_q;
        px_p2_q <= req_x_p1_q;
        py_p2_q <= req_y_p1_q;
        hs_p2_q <= hs_p1_q;
        vs_p2_q <= vs_p1_q;
        fs_p2_q <= fs_p1_q;
      end
    end
  end

  assign req_valid   = req_valid_p1_q;
  assign req_x       = req_x_p1_q;
  assign req_y       = req_y_p1_q;
  assign hsync_n     = hs_p2_q;
  assign vsync_n     = vs_p2_q;
  assign de          = de_p2_q;
  assign pixel_x     = px_p2_q;
  assign pixel_y     = py_p2_q;
  assign frame_start = fs_p2_q;
  assign running     = (state_q == RUN);

endmodule

// File: tb/tb_ili9341_rgb_timing.sv
// Scoreboard bench for ili9341_rgb_timing on a scaled-down raster (15x12 totals,
// 6x5 active) so several frames, lock loss, disable and reset all fit a short run.
module tb_ili9341_rgb_timing;

  localparam int H_ACTIVE  = 6;
  localparam int H_FP      = 2;
  localparam int H_SYNC    = 3;
  localparam int H_BP      = 4;
  localparam int V_ACTIVE  = 5;
  localparam int V_FP      = 3;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 2;
  localparam int LOCK_WAIT = 16;
  localparam int H_TOTAL   = 15;   // 3+4+6+2
  localparam int V_TOTAL   = 12;   // 2+2+5+3
  localparam int FRAME     = 180;  // 15*12
  localparam int IDLE_VEC  = 3 << 16;  // hsync_n=1, vsync_n=1, everything else 0

  logic       clk;
  logic       reset_n;
  logic       locked;
  logic       enable;
  logic       req_valid;
  logic [2:0] req_x;
  logic [2:0] req_y;
  logic       hsync_n;
  logic       vsync_n;
  logic       de;
  logic [2:0] pixel_x;
  logic [2:0] pixel_y;
  logic       frame_start;
  logic       running;

  ili9341_rgb_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .LOCK_WAIT(LOCK_WAIT)
  ) dut (
    .clock_in(clk), .reset_n(reset_n), .locked(locked), .enable(enable),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .de(de),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start), .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int exp_q[$];
  logic mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int out_vec();
    return int'({hsync_n, vsync_n, de, req_valid, frame_start, running,
                 pixel_x, pixel_y, req_x, req_y});
  endfunction

  // Expected DE sequence for one frame, row-major from (0,0).
  task automatic push_frame();
    for (int y = 0; y < V_ACTIVE; y++)
      for (int x = 0; x < H_ACTIVE; x++)
        exp_q.push_back(y * 256 + x);
  endtask

  function automatic logic sig_val(input int sel);
    case (sel)
      0:       return running;
      1:       return frame_start;
      default: return req_valid;
    endcase
  endfunction

  // Counts rising clock edges until the selected output reaches level (bounded).
  task automatic wait_for(input int sel, input logic level, input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (sig_val(sel) !== level && n < limit);
  endtask

  // Monitor: pops expected pixels on DE, checks req->DE alignment and sync/DE widths.
  int   hs_run, vs_run, de_run;
  int   prev_req_vec;
  always @(negedge clk) begin
    if (!mon_en) begin
      hs_run = 0;
      vs_run = 0;
      de_run = 0;
      prev_req_vec = 0;
    end else begin
      if (de) begin
        if (exp_q.size() == 0)
          check("de_unexpected", int'(pixel_y) * 256 + int'(pixel_x), -1);
        else
          check("pixel_coord", int'(pixel_y) * 256 + int'(pixel_x), exp_q.pop_front());
        check("req_to_de_align", prev_req_vec,
              65536 + int'(pixel_y) * 256 + int'(pixel_x));
        de_run++;
      end else begin
        if (de_run != 0 && running) check("de_run_len", de_run, H_ACTIVE);
        de_run = 0;
      end
      if (!hsync_n) hs_run++;
      else begin
        if (hs_run != 0) check("hsync_low_len", hs_run, H_SYNC);
        hs_run = 0;
      end
      if (!vsync_n) vs_run++;
      else begin
        if (vs_run != 0) check("vsync_low_len", vs_run, V_SYNC * H_TOTAL);
        vs_run = 0;
      end
      if (frame_start) check("frame_start_at_sync", int'({hsync_n, vsync_n, de}), 0);
      prev_req_vec = int'(req_valid) * 65536 + int'(req_y) * 256 + int'(req_x);
    end
  end

  int n;
  initial begin
    reset_n = 1'b0;
    locked  = 1'b1;
    enable  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", out_vec(), IDLE_VEC);

    // Startup: sync (2) + WAIT->STABILIZE (1) + LOCK_WAIT counts -> RUN
    push_frame();
    @(negedge clk);
    reset_n = 1'b1;
    #1 mon_en = 1'b1;
    wait_for(0, 1'b1, 200, n);
    check("release_to_running", n, LOCK_WAIT + 3);
    wait_for(1, 1'b1, 20, n);
    check("running_to_frame_start", n, 2);
    // First request at h=H_SYNC+H_BP of line V_SYNC+V_BP, one stage after the counters.
    wait_for(2, 1'b1, 400, n);
    check("first_req_valid", n + 2, (V_SYNC + V_BP) * H_TOTAL + (H_SYNC + H_BP) + 1);

    // Frame 1 fully delivered by RUN+170; queue frame 2.
    repeat (102) @(posedge clk);
    #1;
    check("frame1_complete", exp_q.size(), 0);
    push_frame();

    // Lock loss during frame 2 at counter index 99 (line 6, x=2).
    repeat (109) @(posedge clk);
    @(negedge clk) locked = 1'b0;
    repeat (2) @(negedge clk);
    locked = 1'b1;
    wait_for(0, 1'b0, 20, n);
    check("lock_loss_latency", n + 2, 3);
    check("idle_after_lock_loss", out_vec(), IDLE_VEC);
    check("partial_frame_left", exp_q.size(), 15);
    exp_q.delete();
    push_frame();
    wait_for(0, 1'b1, 200, n);
    check("relock_to_running", n, LOCK_WAIT + 2);
    wait_for(1, 1'b1, 20, n);
    check("restart_frame_start", n, 2);

    // Disable mid-frame: frame runs out to its last cycle, then stops.
    repeat (90) @(posedge clk);
    @(negedge clk) enable = 1'b0;
    wait_for(0, 1'b0, 400, n);
    check("disable_completes_frame", n + 92, FRAME);
    check("frame3_complete", exp_q.size(), 0);
    check("idle_after_disable", out_vec(), IDLE_VEC);
    repeat (8) @(posedge clk);
    #1;
    check("stays_stopped", int'(running), 0);
    @(negedge clk) enable = 1'b1;
    wait_for(1, 1'b1, 20, n);
    check("reenable_to_frame_start", n, 3);

    // Async reset while both syncs are low (display index 16: h=1, v=1).
    repeat (16) @(posedge clk);
    #1;
    check("pre_reset_syncs_low", int'({hsync_n, vsync_n}), 0);
    mon_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_outputs", out_vec(), IDLE_VEC);

    // Lock glitch at STABILIZE count 8 restarts the lock count.
    push_frame();
    @(negedge clk);
    reset_n = 1'b1;
    #1 mon_en = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk) locked = 1'b0;
    @(negedge clk) locked = 1'b1;
    wait_for(0, 1'b1, 200, n);
    check("glitch_restarts_count", n + 12, 31);
    repeat (185) @(posedge clk);
    #1;
    check("final_frame_complete", exp_q.size(), 0);
    check("still_running", int'(running), 1);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ili9341_rgb_timing.md
Name: ili9341_rgb_timing

Overview:
- Generates ILI9341 RGB-interface video timing in the dot-clock domain: HSYNC, VSYNC, DE, and pixel coordinates.
- Clocked by the dot-clock PLL output. Starts scanning only after the PLL lock indication has been stable for a programmable time.
- Issues a pixel request one cycle ahead of DE so an upstream framebuffer/pattern source with 1-cycle read latency can supply RGB data aligned to DE.

Parameters:
- H_ACTIVE, 240, visible pixels per line
- H_FP, 10, horizontal front porch (cycles)
- H_SYNC, 10, HSYNC low width (cycles)
- H_BP, 20, horizontal back porch (cycles)
- V_ACTIVE, 320, visible lines per frame
- V_FP, 4, vertical front porch (lines)
- V_SYNC, 2, VSYNC low width (lines)
- V_BP, 2, vertical back porch (lines)
- LOCK_WAIT, 1024, consecutive locked cycles required before scanning

Ports:
- clock_in  in  1  dot clock (PLL output)
- reset_n  in  1  asynchronous active-low reset
- locked  in  1  PLL lock indication; treated as asynchronous, double-flopped internally
- enable  in  1  scan enable
- req_valid  out  1  pixel request; data is due on the next cycle
- req_x  out  clog2(H_ACTIVE)  requested column
- req_y  out  clog2(V_ACTIVE)  requested row
- hsync_n  out  1  horizontal sync, active low
- vsync_n  out  1  vertical sync, active low
- de  out  1  data enable
- pixel_x  out  clog2(H_ACTIVE)  column currently on DE
- pixel_y  out  clog2(V_ACTIVE)  row currently on DE
- frame_start  out  1  1-cycle pulse on the first cycle of each frame
- running  out  1  high while in the RUN state

Behaviour:
- Reset values of all outputs: hsync_n=1, vsync_n=1, de=0, req_valid=0, all coordinates 0, frame_start=0, running=0. State resets to WAIT_LOCK with counters at 0.
- Derived totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (280). V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP (328).
- h_cnt wraps H_TOTAL-1 -> 0 and increments v_cnt. v_cnt wraps V_TOTAL-1 -> 0.
- Segment order within a line/frame: SYNC, BP, ACTIVE, FP.
- The active window is h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
- FSM states:
  - WAIT_LOCK: outputs idle, counters held at 0. Goes to STABILIZE when synced locked=1.
  - STABILIZE: counts cycles with locked=1. Returns to WAIT_LOCK if locked=0. When the count reaches LOCK_WAIT-1 and enable=1, goes to RUN. The count saturates while enable=0.
  - RUN: counters advance every cycle and running=1.
    - enable deasserted mid-frame: the current frame completes, then at the v_cnt/h_cnt wrap to (0,0) the FSM goes to STABILIZE (saturated), outputs idle.
    - synced locked=0 in RUN: goes to WAIT_LOCK immediately; next cycle all outputs are at reset values and counters are 0. No partial-frame completion.
- Pipeline:
  - Stage 1: req_valid/req_x/req_y are registered from (h_cnt, v_cnt). req_x = h_cnt-(H_SYNC+H_BP), req_y = v_cnt-(V_SYNC+V_BP); both are 0 outside the window.
  - Stage 2: de/pixel_x/pixel_y are req_valid/req_x/req_y delayed one cycle.
  - hsync_n (low when h_cnt<H_SYNC) and vsync_n (low when v_cnt<V_SYNC) are computed at stage 1 and also delayed one cycle, so all display outputs are mutually aligned.
  - frame_start is stage-2 aligned and pulses when the display stage is at (0,0).
- Guarantees per frame: hsync_n low for exactly H_SYNC cycles per line, on every line including porches. vsync_n low for exactly V_SYNC*H_TOTAL cycles. de high for V_ACTIVE runs of exactly H_ACTIVE consecutive cycles.
- Reset asserted mid-frame: outputs go to reset values asynchronously. After release, the block restarts from WAIT_LOCK.
- Coordinates never exceed H_ACTIVE-1 / V_ACTIVE-1.

Test Plan:
- Hold locked=1 and enable=1 from reset -> running rises LOCK_WAIT+2 (sync) +1 cycles after reset release (±1, constant). The first frame_start follows 2 cycles later, coincident with the hsync_n and vsync_n falling edges.
- One full frame with defaults -> hsync_n low 10 cycles every 280. vsync_n low 560 cycles every 91840. de high 320 runs of 240. The first de cycle has pixel (0,0); the last has (239,319).
- Check req/de alignment -> every de=1 cycle has req_valid=1 exactly one cycle earlier with identical x/y. req_valid rises at h_cnt=30 of line v=4.
- Pulse locked=0 for 2 cycles at line 100 -> the next-next cycle shows idle outputs and running=0. The block then waits LOCK_WAIT locked cycles and restarts with frame_start at (0,0).
- Deassert enable at line 50 -> the frame completes through v_cnt=327, h_cnt=279. Then running=0 with outputs idle. Re-assert enable -> a new frame_start follows within 3 cycles.
- Toggle locked during STABILIZE at count 500 -> the count restarts. Assert reset_n=0 mid-RUN -> outputs return to reset values without waiting for a clock edge.
